// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - RV32M multiply/divide unit for the EX stage
// Multiplies finish in one registered product cycle; div/rem use a 32-step restoring divider.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [4:0]      alu_sel_in,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] ALL_ONE = 32'hFFFF_FFFF;

  logic [1:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] mag_b_q, mag_b_d;
  logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d;
  logic [31:0] result_q, result_d;

  logic        start;
  logic [2:0]  op_in;
  logic        in_a_signed, in_b_signed, in_sign_a, in_sign_b;
  logic [31:0] mag_a, mag_b;
  logic        div_by_zero, div_ovf;
  logic [31:0] special_res;
  logic [63:0] prod;
  logic [32:0] rem_shift, diff;
  logic [31:0] quo_next, rem_next, q_final, r_final;

  assign op_in       = alu_sel_in[2:0];
  assign start       = valid_in & (alu_sel_in[4:3] == 2'b01) & (state_q == S_IDLE) & ~flush & ~reset;
  assign in_a_signed = (op_in == 3'b001) | (op_in == 3'b010) | (op_in == 3'b100) | (op_in == 3'b110);
  assign in_b_signed = (op_in == 3'b001) | (op_in == 3'b100) | (op_in == 3'b110);
  assign in_sign_a   = in_a_signed & operand_a[31];
  assign in_sign_b   = in_b_signed & operand_b[31];
  assign mag_a       = in_sign_a ? -operand_a : operand_a;
  assign mag_b       = in_sign_b ? -operand_b : operand_b;
  assign div_by_zero = (operand_b == 32'd0);
  assign div_ovf     = ~op_in[0] & (operand_a == INT_MIN) & (operand_b == ALL_ONE);
  assign special_res = div_by_zero ? (op_in[1] ? operand_a : ALL_ONE)
                                   : (op_in[1] ? 32'd0 : INT_MIN);

  // Sign flags already encode the 33-bit sign/zero extension for each op.
  assign prod = $signed({{32{sign_a_q}}, a_q}) * $signed({{32{sign_b_q}}, b_q});

  assign rem_shift = {rem_q, quo_q[31]};
  assign diff      = rem_shift - {1'b0, mag_b_q};
  assign quo_next  = {quo_q[30:0], ~diff[32]};
  assign rem_next  = diff[32] ? rem_shift[31:0] : diff[31:0];
  assign q_final   = (sign_a_q ^ sign_b_q) ? -quo_next : quo_next;
  assign r_final   = sign_a_q ? -rem_next : rem_next;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    mag_b_d  = mag_b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = op_in[1:0];
          a_d      = operand_a;
          b_d      = operand_b;
          mag_b_d  = mag_b;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          cnt_d    = 6'd0;
          rem_d    = 32'd0;
          quo_d    = mag_a;
          if (!op_in[2]) begin
            state_d = S_MUL;
          end else if (div_by_zero || div_ovf) begin
            state_d  = S_DONE;
            result_d = special_res;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_DONE;
          result_d = (op_q == 2'b00) ? prod[31:0] : prod[63:32];
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_next;
          quo_d = quo_next;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d  = S_DONE;
            result_d = op_q[1] ? r_final : q_final;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 2'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      mag_b_q  <= 32'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= 6'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mag_b_q  <= mag_b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
    end
  end

  assign busy   = start | (state_q == S_MUL) | (state_q == S_DIV);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed-vector bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic [4:0]  alu_sel_in;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [4:0] OP_MUL    = 5'b01000;
  localparam logic [4:0] OP_MULH   = 5'b01001;
  localparam logic [4:0] OP_MULHSU = 5'b01010;
  localparam logic [4:0] OP_MULHU  = 5'b01011;
  localparam logic [4:0] OP_DIV    = 5'b01100;
  localparam logic [4:0] OP_DIVU   = 5'b01101;
  localparam logic [4:0] OP_REM    = 5'b01110;
  localparam logic [4:0] OP_REMU   = 5'b01111;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .alu_sel_in (alu_sel_in),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Holds the instruction in EX until done, as the stalled pipeline would.
  task automatic run_op(input string tag, input logic [4:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int busy_cyc;
    valid_in   = 1'b1;
    alu_sel_in = sel;
    operand_a  = a;
    operand_b  = b;
    #1;
    check_eq({tag, " busy_at_start"}, {31'd0, busy}, 32'd1);
    busy_cyc = 1;
    lat      = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (busy && !done) busy_cyc++;
    end while (!done && lat < 100);
    check_eq({tag, " done"}, {31'd0, done}, 32'd1);
    check_eq({tag, " latency"}, lat, exp_lat);
    check_eq({tag, " busy_cycles"}, busy_cyc, exp_lat);
    check_eq({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
    check_eq({tag, " result"}, result, exp_res);
    valid_in   = 1'b0;
    alu_sel_in = 5'd0;
  endtask

  task automatic gap(input string tag, input logic [31:0] exp_res);
    @(posedge clk); #1;
    check_eq({tag, " done_single_pulse"}, {31'd0, done}, 32'd0);
    check_eq({tag, " result_held"}, result, exp_res);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int done_cnt;
    int busy_cnt;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    check_eq({tag, " no_done"}, done_cnt, 0);
    check_eq({tag, " no_busy"}, busy_cnt, 0);
  endtask

  initial begin
    reset      = 1'b1;
    valid_in   = 1'b0;
    alu_sel_in = 5'd0;
    operand_a  = 32'd0;
    operand_b  = 32'd0;
    flush      = 1'b0;
    #12;
    check_eq("reset busy", {31'd0, busy}, 32'd0);
    check_eq("reset done", {31'd0, done}, 32'd0);
    check_eq("reset result", result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("mul", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
    gap("mul", 32'hFFFF_FFEB);
    run_op("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    gap("mulhu", 32'hFFFF_FFFE);
    run_op("mulh", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2);
    gap("mulh", 32'h0000_0000);
    run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 2);
    gap("mulhsu", 32'hFFFF_FFFF);

    run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    gap("divu", 32'd14);
    run_op("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    gap("remu", 32'd2);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    gap("div_neg", 32'hFFFF_FFFD);
    run_op("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    gap("rem_neg", 32'hFFFF_FFFF);
    run_op("div_negb", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    gap("div_negb", 32'hFFFF_FFFD);
    run_op("rem_negb", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    gap("rem_negb", 32'd1);
    run_op("divu_min", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    gap("divu_min", 32'd0);
    run_op("remu_min", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    gap("remu_min", 32'h8000_0000);

    run_op("div_by0", OP_DIV, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1);
    gap("div_by0", 32'hFFFF_FFFF);
    run_op("remu_by0", OP_REMU, 32'd5, 32'd0, 32'd5, 1);
    gap("remu_by0", 32'd5);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    gap("div_ovf", 32'h8000_0000);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    gap("rem_ovf", 32'd0);
    run_op("mul_seed", OP_MUL, 32'd6, 32'd7, 32'd42, 2);
    gap("mul_seed", 32'd42);

    // Flush during iteration 15 of a divide.
    valid_in   = 1'b1;
    alu_sel_in = OP_DIVU;
    operand_a  = 32'd1000;
    operand_b  = 32'd3;
    repeat (16) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    check_eq("flush busy_before", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    flush    = 1'b0;
    valid_in = 1'b0;
    #1;
    check_eq("flush idle_busy", {31'd0, busy}, 32'd0);
    check_eq("flush idle_done", {31'd0, done}, 32'd0);
    watch_quiet("flush", 40);
    check_eq("flush result_kept", result, 32'd42);
    run_op("after_flush", OP_DIVU, 32'd1000, 32'd3, 32'd333, 33);
    gap("after_flush", 32'd333);

    // Flush while idle blocks a start.
    valid_in   = 1'b1;
    alu_sel_in = OP_MUL;
    flush      = 1'b1;
    #1;
    check_eq("idle_flush busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    valid_in = 1'b0;
    flush    = 1'b0;
    watch_quiet("idle_flush", 5);

    valid_in   = 1'b0;
    alu_sel_in = OP_DIV;
    operand_a  = 32'd9;
    operand_b  = 32'd3;
    #1;
    check_eq("bubble busy", {31'd0, busy}, 32'd0);
    watch_quiet("bubble", 40);
    valid_in   = 1'b1;
    alu_sel_in = 5'b00000;
    #1;
    check_eq("non_m busy", {31'd0, busy}, 32'd0);
    watch_quiet("non_m", 40);
    valid_in   = 1'b0;
    check_eq("non_m result_kept", result, 32'd333);

    run_op("b2b_mul", OP_MUL, 32'd3, 32'd5, 32'd15, 2);
    gap("b2b_mul", 32'd15);
    run_op("b2b_divu", OP_DIVU, 32'd50, 32'd6, 32'd8, 33);
    gap("b2b_divu", 32'd8);

    // Reset asserted ten cycles into a divide.
    valid_in   = 1'b1;
    alu_sel_in = OP_DIVU;
    operand_a  = 32'd100;
    operand_b  = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("mid_reset busy", {31'd0, busy}, 32'd0);
    check_eq("mid_reset done", {31'd0, done}, 32'd0);
    check_eq("mid_reset result", result, 32'd0);
    valid_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    watch_quiet("post_reset", 40);
    run_op("post_reset_mul", OP_MUL, 32'd9, 32'd9, 32'd81, 2);
    gap("post_reset_mul", 32'd81);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
